cursor_overlay: RTL and testbench
=================================

# cursor_overlay

Draws the on-screen cursor that `move_control` positions. Sits in the video path between the pattern/background generator and the HDMI/VGA output stage. Latches `cx`/`cy` once per frame and overlays a hollow square on the incoming pixel stream. When the cursor rests on a movement bound, the square blinks in a warning colour. All outputs are registered, giving one pixel clock of latency with sync and data kept aligned.

## Interface
Parameters:
- `H_ACTIVE`, 11'd640, active pixels per line (x counter saturates at 2047 regardless)
- `START_X`, 11'd320, latched cx after reset
- `START_Y`, 11'd240, latched cy after reset
- `RADIUS`, 11'd8, half-size of the square in pixels
- `THICK`, 11'd2, outline thickness in pixels (1 ≤ THICK ≤ RADIUS+1)
- `MIN_X`, 11'd30; `MAX_X`, 11'd610; `MIN_Y`, 11'd30; `MAX_Y`, 11'd450; bound values that trigger edge blink
- `BLINK_FRAMES`, 8'd30, frames per blink phase (≥1)
- `CURSOR_COLOR`, 24'hFF0000, normal cursor RGB
- `EDGE_COLOR`, 24'hFFFF00, cursor RGB while blinking on

Ports:
- `pixel_clk`  in  1  pixel clock
- `rst`  in  1  synchronous, active-high reset
- `vs`, `hs`, `de`  in  1 each  input sync/data-enable, active-high
- `rgb_in`  in  24  background pixel
- `cx`, `cy`  in  11 each  cursor centre from move_control
- `vs_out`, `hs_out`, `de_out`  out  1 each  inputs delayed 1 cycle
- `rgb_out`  out  24  composited pixel

## Operation
- Frame tick: `vs_rise = vs & ~vs_d`. `vs_d` resets to 1, so there is no tick in the first cycle after reset.
- Position latch: on `vs_rise`, `cx_l <= cx` and `cy_l <= cy`. Mid-frame changes to `cx`/`cy` have no effect until the next tick.
- Pixel coordinates:
  - A cycle with `de=1` has coordinate (`x_cnt`, `y_cnt`); `x_cnt` then increments, saturating at 2047.
  - The first `de=0` cycle after a `de=1` cycle (de falling) sets `x_cnt <= 0` and `y_cnt <= y_cnt+1`, saturating at 2047.
  - `vs_rise` clears both counters and takes priority over de falling.
- Hit test, with `dx = x_cnt - cx_l` and `dy = y_cnt - cy_l` computed as 12-bit signed values (no unsigned wrap):
  - Hit iff |dx| ≤ RADIUS, |dy| ≤ RADIUS, and (|dx| > RADIUS-THICK or |dy| > RADIUS-THICK).
  - Squares that overlap the screen edge are clipped naturally.
- Blink FSM, states `NORMAL`, `EDGE_ON`, `EDGE_OFF`. It updates only on `vs_rise` and evaluates `at_edge` on the freshly latched `cx`/`cy`.
  - `at_edge` means cx==MIN_X, cx==MAX_X, cy==MIN_Y or cy==MAX_Y.
  - `NORMAL`: if at_edge → `EDGE_ON` with `fcnt <= 1`; otherwise stay.
  - `EDGE_ON`/`EDGE_OFF`: if !at_edge → `NORMAL` with `fcnt <= 0`.
  - Else if `fcnt == BLINK_FRAMES`, toggle ON↔OFF with `fcnt <= 1`.
  - Else `fcnt++`.
- Colour select:
  - `de=0` → 0.
  - Hit in `NORMAL` → CURSOR_COLOR.
  - Hit in `EDGE_ON` → EDGE_COLOR.
  - Hit in `EDGE_OFF`, or no hit → `rgb_in`.

## Timing
- Latency: exactly 1 cycle from any input to its corresponding output. `rgb_out` in cycle n+1 reflects `de`/`rgb_in`/counters from cycle n.
- Hit test and colour select are combinational within that single register stage. There is no further pipelining, and there is no handshake or backpressure.
- Frame boundary: the latch, the FSM update and the counter clear all occur in the same cycle as `vs_rise`. The first active pixel of the frame uses the new values.
- Reset, effective on the next edge and also when asserted mid-frame:
  - `vs_out`, `hs_out`, `de_out`, `rgb_out` = 0.
  - `x_cnt`, `y_cnt`, `fcnt` = 0.
  - `cx_l` = START_X, `cy_l` = START_Y.
  - State = `NORMAL`, `vs_d` = 1.
  - After release, coordinates are undefined-but-deterministic until the first `vs_rise` realigns them.
- Simultaneous `vs_rise` and de falling: the clear wins, giving `y_cnt=0`.

## Structure
- Shared package `cursor_pkg` holds:
  - The 11-bit coordinate width constant.
  - The blink state enum (`NORMAL`, `EDGE_ON`, `EDGE_OFF`).
  - Default colour constants, shared with the background generator.
- One natural sub-module, `pixel_pos_counter`. It owns `vs_d`, `vs_rise`, the de-falling detect and `x_cnt`/`y_cnt`, and is reusable by other overlays.
- Hit test, FSM and output register stay in `cursor_overlay`.

## Test plan
- Reset: hold `rst` 3 cycles mid-line with `de=1` → all outputs 0 next cycle; after release plus `vs_rise`, square is centred at 320,240.
- Shape, with defaults, cx=320, cy=240, background 24'h000040:
  - Pixels (312,240), (313,235) and (328,248) → FF0000.
  - Pixels (320,240), (314,240) and (329,240) → 000040.
  - Each appears one cycle after its input pixel.
- Latch: change cx 320→400 mid-frame → current frame is unchanged; the next frame has its square at 400.
- Edge blink: cx=30, cy=240 held:
  - Frames 1–30 → square FFFF00.
  - Frames 31–60 → square absent (passthrough).
  - Frame 61 → FFFF00 again.
- Leave edge during `EDGE_OFF`: cx=34 on next tick → FF0000 in that same frame, `fcnt=0`.
- Clipping and blanking: cx=30, cy=30, RADIUS=40 → no wrap artefacts at x≈2040; `de=0` cycles always yield `rgb_out=0`, and `hs_out`/`vs_out` track their inputs delayed by 1 cycle.

Source files
------------

// File: rtl/cursor_pkg.sv
// Shared definitions for cursor overlays and the background generator:
// coordinate width, blink states, default colours and a saturating step.
package cursor_pkg;

  localparam int COORD_W = 11;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    EDGE_ON  = 2'd1,
    EDGE_OFF = 2'd2
  } blink_state_t;

  localparam logic [23:0] DEFAULT_CURSOR_COLOR = 24'hFF0000;
  localparam logic [23:0] DEFAULT_EDGE_COLOR   = 24'hFFFF00;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Tracks the raster position of the current pixel from vs/de alone.
// Also exposes the frame tick so overlays can latch per-frame state.
module pixel_pos_counter
  import cursor_pkg::*;
(
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               i_vs,
  input  logic               i_de,
  output logic               o_vs_rise,
  output logic [COORD_W-1:0] o_x_cnt,
  output logic [COORD_W-1:0] o_y_cnt
);

  logic               r_vs_d;
  logic               r_de_d;
  logic [COORD_W-1:0] r_x_cnt;
  logic [COORD_W-1:0] r_y_cnt;
  logic               w_de_fall;

  // r_vs_d comes out of reset high so a vs held high through reset is not a tick
  assign o_vs_rise = i_vs & ~r_vs_d;
  assign w_de_fall = ~i_de & r_de_d;
  assign o_x_cnt   = r_x_cnt;
  assign o_y_cnt   = r_y_cnt;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_vs_d  <= 1'b1;
      r_de_d  <= 1'b0;
      r_x_cnt <= '0;
      r_y_cnt <= '0;
    end else begin
      r_vs_d <= i_vs;
      r_de_d <= i_de;
      if (o_vs_rise) begin
        r_x_cnt <= '0;
        r_y_cnt <= '0;
      end else if (i_de) begin
        r_x_cnt <= sat_inc(r_x_cnt);
      end else if (w_de_fall) begin
        r_x_cnt <= '0;
        r_y_cnt <= sat_inc(r_y_cnt);
      end
    end
  end

endmodule

// File: rtl/cursor_overlay.sv
// Overlays a hollow square cursor on the video stream, latched once per frame,
// blinking in a warning colour while the cursor rests on a movement bound.
module cursor_overlay
  import cursor_pkg::*;
#(
  parameter logic [10:0] H_ACTIVE     = 11'd640,
  parameter logic [10:0] START_X      = 11'd320,
  parameter logic [10:0] START_Y      = 11'd240,
  parameter logic [10:0] RADIUS       = 11'd8,
  parameter logic [10:0] THICK        = 11'd2,
  parameter logic [10:0] MIN_X        = 11'd30,
  parameter logic [10:0] MAX_X        = 11'd610,
  parameter logic [10:0] MIN_Y        = 11'd30,
  parameter logic [10:0] MAX_Y        = 11'd450,
  parameter logic [7:0]  BLINK_FRAMES = 8'd30,
  parameter logic [23:0] CURSOR_COLOR = DEFAULT_CURSOR_COLOR,
  parameter logic [23:0] EDGE_COLOR   = DEFAULT_EDGE_COLOR
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        hs,
  input  logic        de,
  input  logic [23:0] rgb_in,
  input  logic [10:0] cx,
  input  logic [10:0] cy,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [23:0] rgb_out
);

  if (THICK == 11'd0 || {1'b0, THICK} > {1'b0, RADIUS} + 12'd1 ||
      BLINK_FRAMES == 8'd0 || H_ACTIVE == 11'd0) begin : g_bad_config
    $error("cursor_overlay: illegal parameter combination");
  end

  localparam logic [11:0]        RAD12 = {1'b0, RADIUS};
  localparam logic signed [12:0] INNER = $signed({2'b00, RADIUS}) - $signed({2'b00, THICK});

  logic               w_vs_rise;
  logic [COORD_W-1:0] w_x_cnt;
  logic [COORD_W-1:0] w_y_cnt;

  logic [10:0]  r_cx_l;
  logic [10:0]  r_cy_l;
  blink_state_t r_state;
  logic [7:0]   r_fcnt;
  blink_state_t w_state_nxt;
  logic [7:0]   w_fcnt_nxt;
  logic         w_at_edge;

  logic signed [11:0] w_dx;
  logic signed [11:0] w_dy;
  logic [11:0]        w_adx;
  logic [11:0]        w_ady;
  logic               w_hit;
  logic [23:0]        w_rgb_nxt;

  logic        r_vs_out;
  logic        r_hs_out;
  logic        r_de_out;
  logic [23:0] r_rgb_out;

  pixel_pos_counter u_pos (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .i_vs      (vs),
    .i_de      (de),
    .o_vs_rise (w_vs_rise),
    .o_x_cnt   (w_x_cnt),
    .o_y_cnt   (w_y_cnt)
  );

  // Judged on the live cx/cy because the FSM only moves in the tick that latches them
  assign w_at_edge = (cx == MIN_X) || (cx == MAX_X) || (cy == MIN_Y) || (cy == MAX_Y);

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (w_vs_rise) begin
      unique case (r_state)
        NORMAL: begin
          if (w_at_edge) begin
            w_state_nxt = EDGE_ON;
            w_fcnt_nxt  = 8'd1;
          end
        end
        EDGE_ON, EDGE_OFF: begin
          if (!w_at_edge) begin
            w_state_nxt = NORMAL;
            w_fcnt_nxt  = 8'd0;
          end else if (r_fcnt == BLINK_FRAMES) begin
            w_state_nxt = (r_state == EDGE_ON) ? EDGE_OFF : EDGE_ON;
            w_fcnt_nxt  = 8'd1;
          end else begin
            w_fcnt_nxt = r_fcnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = NORMAL;
          w_fcnt_nxt  = 8'd0;
        end
      endcase
    end
  end

  // One extra bit keeps offsets signed so a square near x=0 never wraps to x~2047
  assign w_dx  = $signed({1'b0, w_x_cnt}) - $signed({1'b0, r_cx_l});
  assign w_dy  = $signed({1'b0, w_y_cnt}) - $signed({1'b0, r_cy_l});
  assign w_adx = w_dx[11] ? $unsigned(-w_dx) : $unsigned(w_dx);
  assign w_ady = w_dy[11] ? $unsigned(-w_dy) : $unsigned(w_dy);
  assign w_hit = (w_adx <= RAD12) && (w_ady <= RAD12) &&
                 (($signed({1'b0, w_adx}) > INNER) || ($signed({1'b0, w_ady}) > INNER));

  always_comb begin
    w_rgb_nxt = rgb_in;
    if (!de) begin
      w_rgb_nxt = 24'h000000;
    end else if (w_hit && r_state == NORMAL) begin
      w_rgb_nxt = CURSOR_COLOR;
    end else if (w_hit && r_state == EDGE_ON) begin
      w_rgb_nxt = EDGE_COLOR;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_vs_out  <= 1'b0;
      r_hs_out  <= 1'b0;
      r_de_out  <= 1'b0;
      r_rgb_out <= 24'h000000;
      r_cx_l    <= START_X;
      r_cy_l    <= START_Y;
      r_state   <= NORMAL;
      r_fcnt    <= 8'd0;
    end else begin
      r_vs_out  <= vs;
      r_hs_out  <= hs;
      r_de_out  <= de;
      r_rgb_out <= w_rgb_nxt;
      r_state   <= w_state_nxt;
      r_fcnt    <= w_fcnt_nxt;
      if (w_vs_rise) begin
        r_cx_l <= cx;
        r_cy_l <= cy;
      end
    end
  end

  assign vs_out  = r_vs_out;
  assign hs_out  = r_hs_out;
  assign de_out  = r_de_out;
  assign rgb_out = r_rgb_out;

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed bench for cursor_overlay: a default instance and a RADIUS=40 instance
// share inputs; expectations are queued per driven cycle and popped one cycle later.
module tb_cursor_overlay;

  logic        pixelClk = 1'b0;
  logic        rst      = 1'b1;
  logic        vs       = 1'b0;
  logic        hs       = 1'b0;
  logic        de       = 1'b0;
  logic [23:0] rgbIn    = 24'h0;
  logic [10:0] cxIn     = 11'd100;
  logic [10:0] cyIn     = 11'd100;

  logic        vsOutA, hsOutA, deOutA;
  logic [23:0] rgbOutA;
  logic        vsOutB, hsOutB, deOutB;
  logic [23:0] rgbOutB;

  typedef struct {
    logic        vs;
    logic        hs;
    logic        de;
    logic [23:0] rgbA;
    logic [23:0] rgbB;
    int          x;
    int          y;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int   bx, by, cxl, cyl, expMode;
  logic prevVs, prevDe;

  always #5 pixelClk = ~pixelClk;

  cursor_overlay dutA (
    .pixel_clk (pixelClk), .rst (rst), .vs (vs), .hs (hs), .de (de),
    .rgb_in (rgbIn), .cx (cxIn), .cy (cyIn),
    .vs_out (vsOutA), .hs_out (hsOutA), .de_out (deOutA), .rgb_out (rgbOutA)
  );

  cursor_overlay #(.RADIUS(11'd40)) dutB (
    .pixel_clk (pixelClk), .rst (rst), .vs (vs), .hs (hs), .de (de),
    .rgb_in (rgbIn), .cx (cxIn), .cy (cyIn),
    .vs_out (vsOutB), .hs_out (hsOutB), .de_out (deOutB), .rgb_out (rgbOutB)
  );

  // Expected colour from pixel geometry; mode 0=cursor colour, 1=warning colour, 2=hidden
  function automatic logic [23:0] expColour(input logic d, input logic [23:0] bg,
                                            input int x, input int y, input int cxv,
                                            input int cyv, input int radius,
                                            input int thick, input int mode);
    int  adx, ady;
    bit  hit;
    if (!d) return 24'h000000;
    adx = (x > cxv) ? x - cxv : cxv - x;
    ady = (y > cyv) ? y - cyv : cyv - y;
    hit = (adx <= radius) && (ady <= radius) &&
          ((adx > radius - thick) || (ady > radius - thick));
    if (!hit) return bg;
    if (mode == 0) return 24'hFF0000;
    if (mode == 1) return 24'hFFFF00;
    return bg;
  endfunction

  task automatic checkOutput(input exp_t e);
    total++;
    assert ({vsOutA, hsOutA, deOutA} === {e.vs, e.hs, e.de}) else begin
      bad++;
      $error("[TB] FAIL syncA at (%0d,%0d): got=%b expected=%b", e.x, e.y,
             {vsOutA, hsOutA, deOutA}, {e.vs, e.hs, e.de});
    end
    total++;
    assert ({vsOutB, hsOutB, deOutB} === {e.vs, e.hs, e.de}) else begin
      bad++;
      $error("[TB] FAIL syncB at (%0d,%0d): got=%b expected=%b", e.x, e.y,
             {vsOutB, hsOutB, deOutB}, {e.vs, e.hs, e.de});
    end
    total++;
    assert (rgbOutA === e.rgbA) else begin
      bad++;
      $error("[TB] FAIL rgbA at (%0d,%0d): got=%h expected=%h", e.x, e.y, rgbOutA, e.rgbA);
    end
    total++;
    assert (rgbOutB === e.rgbB) else begin
      bad++;
      $error("[TB] FAIL rgbB at (%0d,%0d): got=%h expected=%h", e.x, e.y, rgbOutB, e.rgbB);
    end
  endtask

  // One pixel clock: check the previous cycle's output, drive, queue expectation, advance raster
  task automatic applyStimulus(input logic iRst, input logic iVs, input logic iHs,
                               input logic iDe, input logic [23:0] iRgb);
    exp_t e;
    @(negedge pixelClk);
    if (sb.size() != 0) checkOutput(sb.pop_front());
    rst   = iRst;
    vs    = iVs;
    hs    = iHs;
    de    = iDe;
    rgbIn = iRgb;
    e.x = bx;
    e.y = by;
    if (iRst) begin
      e.vs = 1'b0; e.hs = 1'b0; e.de = 1'b0; e.rgbA = 24'h0; e.rgbB = 24'h0;
    end else begin
      e.vs   = iVs;
      e.hs   = iHs;
      e.de   = iDe;
      e.rgbA = expColour(iDe, iRgb, bx, by, cxl, cyl, 8, 2, expMode);
      e.rgbB = expColour(iDe, iRgb, bx, by, cxl, cyl, 40, 2, expMode);
    end
    sb.push_back(e);
    if (iRst) begin
      bx = 0; by = 0; cxl = 320; cyl = 240; prevVs = 1'b1; prevDe = 1'b0;
    end else begin
      if (iVs && !prevVs) begin
        bx = 0; by = 0; cxl = int'(cxIn); cyl = int'(cyIn);
      end else if (iDe) begin
        bx = (bx == 2047) ? 2047 : bx + 1;
      end else if (prevDe) begin
        bx = 0;
        by = (by == 2047) ? 2047 : by + 1;
      end
      prevVs = iVs;
      prevDe = iDe;
    end
  endtask

  task automatic tick(input logic withIdle);
    if (withIdle) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom()));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'($urandom()));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom()));
  endtask

  task automatic drawRows(input int yStart, input int yEnd, input int xLen,
                          input logic useConst);
    while (by < yStart) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'($urandom()));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 24'($urandom()));
    end
    for (int r = yStart; r <= yEnd; r++) begin
      for (int i = 0; i < xLen; i++)
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, useConst ? 24'h000040 : 24'($urandom()));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 24'($urandom()));
    end
  endtask

  initial begin
    bx = 0; by = 0; cxl = 320; cyl = 240; expMode = 0;
    prevVs = 1'b1; prevDe = 1'b0;

    // Reset, a few live pixels, then a 3-cycle reset in the middle of a line
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'($urandom()));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 24'($urandom()));

    // vs already high on release is not a tick, so the square stays at START_X/START_Y
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'($urandom()));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom()));
    drawRows(232, 248, 331, 1'b0);

    // Shape frame at 320,240 on a flat background; cx moves mid-frame without effect
    cxIn = 11'd320; cyIn = 11'd240; expMode = 0;
    tick(1'b1);
    cxIn = 11'd400;
    drawRows(232, 248, 331, 1'b1);

    // Tick in the same cycle as de falling: the clear must win
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'($urandom()));
    tick(1'b0);
    drawRows(232, 248, 410, 1'b0);

    // Edge blink on cx=30, then leave the edge during an off phase
    cxIn = 11'd30;
    for (int k = 1; k <= 92; k++) begin
      if (k == 92) begin
        cxIn = 11'd34;
        expMode = 0;
      end else begin
        expMode = (((k - 1) / 30) % 2 == 0) ? 1 : 2;
      end
      tick(1'b1);
      if (k == 1 || k == 30 || k == 31 || k == 60 || k == 61 || k == 91 || k == 92)
        drawRows(232, 248, 45, 1'b0);
    end

    // Corner cursor: long lines run the x counter into saturation without wrap hits
    cxIn = 11'd30; cyIn = 11'd30; expMode = 1;
    tick(1'b1);
    drawRows(0, 1, 2050, 1'b0);

    @(negedge pixelClk);
    while (sb.size() != 0) checkOutput(sb.pop_front());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
